// File: rtl/multi_digit_display_generator.sv
// Multi-digit active-low 7-segment driver: serial shift-add-3 binary-to-BCD, then parallel digit encode.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module multi_digit_display_generator #(
  parameter int BIN_WIDTH  = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      act_D,
  input  logic [BIN_WIDTH-1:0]      value,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [7*NUM_DIGITS-1:0]   disp_bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int CMP_W = ((BIN_WIDTH > BCD_W) ? BIN_WIDTH : BCD_W) + 1;
  localparam logic [CMP_W-1:0] LIMIT = CMP_W'(10 ** NUM_DIGITS);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] val_q;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  // Walks digits from most significant down so leading-zero state is known per digit.
  function automatic logic [7*NUM_DIGITS-1:0] encode(input logic [BCD_W-1:0] b, input logic o);
    logic [7*NUM_DIGITS-1:0] r;
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    r = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (o) begin
        r[7*k +: 7] = SEG_DASH;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        if (lead && (k != 0) && (b[4*k +: 4] == 4'd0)) begin
          r[7*k +: 7] = SEG_BLANK;
        end else begin
          lead        = 1'b0;
          r[7*k +: 7] = seg7(b[4*k +: 4]);
        end
`else
        r[7*k +: 7] = seg7(b[4*k +: 4]);
`endif
      end
    end
    return r;
  endfunction

  assign bcd_adj = add3(bcd);
  assign ovf     = (CMP_W'(val_q) >= LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      disp_bus <= '1;
      val_q    <= '0;
      bin_sr   <= '0;
      bcd      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (act_D) begin
            val_q  <= value;
            bin_sr <= value;
            bcd    <= '0;
            cnt    <= CNT_W'(BIN_WIDTH);
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          {bcd, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
          cnt           <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= UPDATE;
        end
        UPDATE: begin
          disp_bus <= encode(bcd, ovf);
          overflow <= ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_digit_display_generator.sv
// Randomized self-checking bench: a 3-digit and a 2-digit instance share stimulus and are
// compared against a decimal-arithmetic display model.
module tb_multi_digit_display_generator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        act_D = 1'b0;
  logic [7:0]  value = 8'd0;
  logic        busy3, done3, ovf3;
  logic [20:0] disp3;
  logic        busy2, done2, ovf2;
  logic [13:0] disp2;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [20:0] cur3;
  logic [13:0] cur2;
  logic        cov3, cov2;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};

  multi_digit_display_generator #(.BIN_WIDTH(8), .NUM_DIGITS(3)) u_dut3 (
    .clock(clock), .reset(reset), .act_D(act_D), .value(value),
    .busy(busy3), .done(done3), .overflow(ovf3), .disp_bus(disp3)
  );

  multi_digit_display_generator #(.BIN_WIDTH(8), .NUM_DIGITS(2)) u_dut2 (
    .clock(clock), .reset(reset), .act_D(act_D), .value(value),
    .busy(busy2), .done(done2), .overflow(ovf2), .disp_bus(disp2)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p *= 10;
    return p;
  endfunction

  function automatic logic [31:0] model_bus(input int nd, input int v);
    logic [31:0] r;
    logic [6:0]  s;
    int          p;
    r = '0;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      if (v >= pow10(nd))            s = 7'b0111111;
      else if (LZB && k > 0 && v < p) s = 7'b1111111;
      else                           s = SEG[(v / p) % 10];
      r[7*k +: 7] = s;
      p *= 10;
    end
    return r;
  endfunction

  task automatic set_model(input int v);
    logic [31:0] t3, t2;
    t3   = model_bus(3, v);
    t2   = model_bus(2, v);
    cur3 = t3[20:0];
    cur2 = t2[13:0];
    cov3 = (v >= 1000);
    cov2 = (v >= 100);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_disp3"}, 32'(disp3), 32'(cur3));
    chk({tag, "_disp2"}, 32'(disp2), 32'(cur2));
    chk({tag, "_ovf3"},  32'(ovf3),  32'(cov3));
    chk({tag, "_ovf2"},  32'(ovf2),  32'(cov2));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done3 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // One load of v; inj>0 pulses act_D with 42 while the conversion is in flight.
  task automatic convert(input int v, input int inj, input string tag);
    int lat;
    act_D = 1'b1;
    value = 8'(v);
    @(negedge clock);
    act_D = 1'b0;
    value = 8'($urandom);
    chk({tag, "_busy"}, 32'(busy3), 32'd1);
    chk({tag, "_hold3"}, 32'(disp3), 32'(cur3));
    chk({tag, "_hold2"}, 32'(disp2), 32'(cur2));
    lat = 0;
    while (!done3 && lat < 40) begin
      @(negedge clock);
      lat++;
      if (lat == inj) begin
        act_D = 1'b1;
        value = 8'd42;
      end else begin
        act_D = 1'b0;
      end
    end
    act_D = 1'b0;
    set_model(v);
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    check_outputs(tag);
    chk({tag, "_done2"}, 32'(done2), 32'd1);
    chk({tag, "_idle"}, 32'(busy3), 32'd0);
    @(negedge clock);
    chk({tag, "_pulse"}, 32'(done3), 32'd0);
    chk({tag, "_nobusy"}, 32'(busy3), 32'd0);
  endtask

  initial begin
    int lat;
    int hits;
    int v;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    cur3 = '1;
    cur2 = '1;
    cov3 = 1'b0;
    cov2 = 1'b0;
    chk("rst_disp3", 32'(disp3), 32'h1FFFFF);
    chk("rst_disp2", 32'(disp2), 32'h3FFF);
    chk("rst_busy", 32'({busy3, busy2}), 32'd0);
    chk("rst_done", 32'({done3, done2}), 32'd0);
    chk("rst_ovf", 32'({ovf3, ovf2}), 32'd0);

    convert(255, 0, "v255");
    convert(7,   0, "v7");
    convert(0,   0, "v0");
    convert(100, 0, "v100");
    convert(99,  0, "v99");
    convert(13,  2, "ign");

    hits = 0;
    repeat (12) begin
      @(negedge clock);
      if (done3 || busy3) hits++;
    end
    chk("noqueue", 32'(hits), 32'd0);
    check_outputs("ign_after");

    act_D = 1'b1;
    value = 8'd123;
    @(negedge clock);
    wait_done(lat);
    set_model(123);
    chk("held1_lat", 32'(lat), 32'd9);
    check_outputs("held1");
    value = 8'd58;
    @(negedge clock);
    act_D = 1'b0;
    value = 8'($urandom);
    chk("held_reload", 32'(busy3), 32'd1);
    wait_done(lat);
    set_model(58);
    chk("held2_lat", 32'(lat), 32'd9);
    check_outputs("held2");
    @(negedge clock);

    convert(150, 0, "v150");
    act_D = 1'b1;
    value = 8'd200;
    @(negedge clock);
    act_D = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    cur3 = '1;
    cur2 = '1;
    cov3 = 1'b0;
    cov2 = 1'b0;
    check_outputs("arst");
    chk("arst_busy", 32'({busy3, busy2}), 32'd0);
    chk("arst_done", 32'({done3, done2}), 32'd0);
    hits = 0;
    repeat (3) begin
      @(negedge clock);
      if (done3 || done2) hits++;
    end
    reset = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (done3 || done2 || busy3) hits++;
    end
    chk("arst_nodone", 32'(hits), 32'd0);
    check_outputs("arst_after");
    convert(64, 0, "v64");

    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 255));
      convert(v, int'($urandom_range(0, 8)), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
